program_loader: RTL and testbench

- Memory-side writer that fills the shared `mem` with a program image while the CPU core is held off. It then hands memory back to the fetcher and fires the start pulse.
- Takes over the manual-memory role the benches play today: byte stream in, memory writes out, optional read-back verify, then release.
- Sits between an external byte source and the fetcher/`mem` address and data mux. Its `mem_own` output is the mux select.

---
 rtl/program_loader_pkg.sv | 19 +
 rtl/program_loader_ldr_checksum.sv | 26 ++
 rtl/program_loader.sv | 182 ++++++++++++++++++
 tb/tb_program_loader.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared widths, loader state encodings and the default program base address.
package program_loader_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int REG_WIDTH  = 8;

  localparam logic [ADDR_WIDTH-1:0] INSTRUCTION_BASE = 16'h0200;

  typedef enum logic [2:0] {
    LDR_IDLE   = 3'd0,
    LDR_LOAD   = 3'd1,
    LDR_FLUSH  = 3'd2,
    LDR_VERIFY = 3'd3,
    LDR_CHECK  = 3'd4,
    LDR_DONE   = 3'd5,
    LDR_ERR    = 3'd6
  } ldr_state_e;

endpackage

// File: rtl/program_loader_ldr_checksum.sv
// Modulo-2^DATA_W byte accumulator; clear has priority over enable.
module ldr_checksum
  import program_loader_pkg::*;
#(
  parameter int DATA_W = REG_WIDTH
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] sum_o
);

  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      sum_q <= '0;
    end else if (en_i) begin
      sum_q <= sum_q + data_i;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/program_loader.sv
// Streams a program image into mem while the CPU is parked, optionally
// verifies it with a read-back checksum, then releases mem and fires trigger.
module program_loader #(
  parameter int ADDR_WIDTH = program_loader_pkg::ADDR_WIDTH,
  parameter int REG_WIDTH  = program_loader_pkg::REG_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic                  verify_en,
  input  logic [REG_WIDTH-1:0]  din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_dout,
  output logic                  mem_we,
  input  logic [REG_WIDTH-1:0]  mem_din,
  output logic                  mem_own,
  output logic                  cpu_hold,
  output logic                  trigger,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] count
);

  import program_loader_pkg::*;

  ldr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_WIDTH-1:0]  dout_q, dout_d;
  logic                  verify_q, verify_d;
  logic                  we_q, we_d;
  logic                  trig_q, trig_d;

  logic                  idle_st;
  logic                  start_acc;
  logic                  hs;
  logic                  last_hs;
  logic                  rsum_en;
  logic [REG_WIDTH-1:0]  wsum;
  logic [REG_WIDTH-1:0]  rsum;
  logic [REG_WIDTH-1:0]  rsum_next;

  assign idle_st   = (state_q == LDR_IDLE) || (state_q == LDR_DONE) || (state_q == LDR_ERR);
  assign start_acc = start && idle_st;
  assign din_ready = (state_q == LDR_LOAD) && (count_q != len_q);
  assign hs        = din_valid && din_ready;
  assign last_hs   = hs && (count_q == len_q - ADDR_WIDTH'(1));
  // CHECK compares with the final read word folded in, so no extra cycle is needed.
  assign rsum_next = rsum + mem_din;

  ldr_checksum #(.DATA_W(REG_WIDTH)) u_wsum (
    .clk    (clk),
    .clr_i  (start_acc),
    .en_i   (hs),
    .data_i (din),
    .sum_o  (wsum)
  );

  ldr_checksum #(.DATA_W(REG_WIDTH)) u_rsum (
    .clk    (clk),
    .clr_i  (start_acc),
    .en_i   (rsum_en),
    .data_i (mem_din),
    .sum_o  (rsum)
  );

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    verify_d = verify_q;
    count_d  = count_q;
    rd_idx_d = rd_idx_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    we_d     = 1'b0;
    trig_d   = 1'b0;
    rsum_en  = 1'b0;

    case (state_q)
      LDR_IDLE, LDR_DONE, LDR_ERR: begin
        if (start) begin
          base_d   = base_addr;
          len_d    = length;
          verify_d = verify_en;
          count_d  = '0;
          if (length == '0) begin
            state_d = LDR_DONE;
            trig_d  = 1'b1;
          end else begin
            state_d = LDR_LOAD;
          end
        end
      end
      LDR_LOAD: begin
        if (hs) begin
          we_d    = 1'b1;
          addr_d  = base_q + count_q;
          dout_d  = din;
          count_d = count_q + ADDR_WIDTH'(1);
          if (last_hs) state_d = LDR_FLUSH;
        end
      end
      LDR_FLUSH: begin
        if (verify_q) begin
          state_d  = LDR_VERIFY;
          addr_d   = base_q;
          rd_idx_d = '0;
        end else begin
          state_d = LDR_DONE;
          trig_d  = 1'b1;
        end
      end
      LDR_VERIFY: begin
        // Read data lags the address by one cycle; the first VERIFY cycle has nothing to absorb.
        rsum_en = (rd_idx_q != '0);
        if (rd_idx_q == len_q - ADDR_WIDTH'(1)) begin
          state_d = LDR_CHECK;
        end else begin
          rd_idx_d = rd_idx_q + ADDR_WIDTH'(1);
          addr_d   = addr_q + ADDR_WIDTH'(1);
        end
      end
      LDR_CHECK: begin
        rsum_en = 1'b1;
        if (rsum_next == wsum) begin
          state_d = LDR_DONE;
          trig_d  = 1'b1;
        end else begin
          state_d = LDR_ERR;
        end
      end
      default: state_d = LDR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LDR_IDLE;
      we_q    <= 1'b0;
      trig_q  <= 1'b0;
      count_q <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      trig_q  <= trig_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
    end
  end

  // Load parameters and read pointer are always written before use.
  always_ff @(posedge clk) begin
    base_q   <= base_d;
    len_q    <= len_d;
    verify_q <= verify_d;
    rd_idx_q <= rd_idx_d;
  end

  assign mem_addr = addr_q;
  assign mem_dout = dout_q;
  assign mem_we   = we_q;
  assign mem_own  = (state_q != LDR_DONE);
  assign cpu_hold = (state_q != LDR_DONE);
  assign trigger  = trig_q;
  assign busy     = !idle_st;
  assign done     = (state_q == LDR_DONE);
  assign error    = (state_q == LDR_ERR);
  assign count    = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: synchronous memory model, per-cycle monitor and
// scenario tasks comparing against expectations derived from the load rules.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int MAXC = 8192;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] length;
  logic          verify_en;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout;
  logic          mem_we;
  logic [DW-1:0] mem_din;
  logic          mem_own;
  logic          cpu_hold;
  logic          trigger;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-1:0] count;

  program_loader #(.ADDR_WIDTH(AW), .REG_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .verify_en(verify_en), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_we(mem_we), .mem_din(mem_din), .mem_own(mem_own), .cpu_hold(cpu_hold),
    .trigger(trigger), .busy(busy), .done(done), .error(error), .count(count)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:65535];
  logic          corrupt_en;
  logic [AW-1:0] corrupt_addr;
  logic [DW-1:0] corrupt_val;

  always @(posedge clk) begin
    if (mem_we && mem_own) mem[mem_addr] <= mem_dout;
    if (corrupt_en) mem[corrupt_addr] <= corrupt_val;
    mem_din <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          we_h   [MAXC];
  logic          hs_h   [MAXC];
  logic          rdy_h  [MAXC];
  logic          trig_h [MAXC];
  logic          done_h [MAXC];
  logic          err_h  [MAXC];
  logic [AW-1:0] addr_h [MAXC];
  logic [DW-1:0] dout_h [MAXC];

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      we_h[cyc]   <= mem_we;
      hs_h[cyc]   <= din_valid && din_ready;
      rdy_h[cyc]  <= din_ready;
      trig_h[cyc] <= trigger;
      done_h[cyc] <= done;
      err_h[cyc]  <= error;
      addr_h[cyc] <= mem_addr;
      dout_h[cyc] <= mem_dout;
    end
  end

  int errors = 0;
  int checks = 0;
  int start_cyc;
  logic [DW-1:0] tx_q[$];
  int            gap_q[$];

  int            ob_hs[$];
  int            ob_wc[$];
  logic [AW-1:0] ob_wa[$];
  logic [DW-1:0] ob_wd[$];
  int ob_done, ob_err, ob_trig, ob_trig_cyc, ob_rdy;

  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] l, input logic v);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = l; verify_en = v;
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; base_addr = AW'($urandom); length = AW'($urandom); verify_en = 1'($urandom);
  endtask

  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      repeat (gap_q[i]) @(posedge clk);
      #1;
      din = tx_q[i];
      din_valid = 1'b1;
      @(negedge clk);
      while (!din_ready && t < 50) begin @(negedge clk); t++; end
      checks++;
      if (!din_ready) begin
        errors++;
        $display("FAIL send_ready[%0d]: din_ready=%0b after %0d cycles, required 1", i, din_ready, t);
      end
      @(posedge clk); #1;
      din_valid = 1'b0;
      din = DW'($urandom);
    end
  endtask

  task automatic wait_end(input string name);
    int t = 0;
    @(negedge clk);
    while (!(done || error) && t < 300) begin @(negedge clk); t++; end
    checks++;
    if (!(done || error)) begin
      errors++;
      $display("FAIL %s_end: done=%0b error=%0b after %0d cycles, required done or error", name, done, error, t);
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic collect(input int from);
    ob_hs.delete(); ob_wc.delete(); ob_wa.delete(); ob_wd.delete();
    ob_done = -1; ob_err = -1; ob_trig = 0; ob_trig_cyc = -1; ob_rdy = 0;
    for (int c = (from < 0 ? 0 : from); c <= cyc && c < MAXC; c++) begin
      if (hs_h[c]) ob_hs.push_back(c);
      if (we_h[c]) begin ob_wc.push_back(c); ob_wa.push_back(addr_h[c]); ob_wd.push_back(dout_h[c]); end
      if (done_h[c] && ob_done < 0) ob_done = c;
      if (err_h[c] && ob_err < 0) ob_err = c;
      if (trig_h[c]) begin ob_trig++; ob_trig_cyc = c; end
      if (rdy_h[c]) ob_rdy = 1;
    end
  endtask

  function automatic int last_hs();
    return (ob_hs.size() > 0) ? ob_hs[ob_hs.size()-1] : -1000;
  endfunction

  function automatic int hidx(input int c);
    return (c < 0 || c >= MAXC) ? 0 : c;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cpu_hold, mem_own} !== 2'b11) begin errors++; $display("FAIL reset_hold: cpu_hold,mem_own=%b required 11", {cpu_hold, mem_own}); end
    checks++;
    if ({busy, done, error, trigger, din_ready, mem_we} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: busy,done,error,trigger,din_ready,mem_we=%b required 000000", {busy, done, error, trigger, din_ready, mem_we});
    end
    checks++;
    if ({count, mem_addr, mem_dout} !== 40'h0) begin
      errors++; $display("FAIL reset_data: count=%h mem_addr=%h mem_dout=%h required all 0", count, mem_addr, mem_dout);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [AW-1:0] b;
    int k;
    b = INSTRUCTION_BASE;
    tx_q = '{8'hA9, 8'h05, 8'h69, 8'h03};
    gap_q = '{0, 0, 0, 0};
    do_start(b, 16'd4, 1'b0);
    send_bytes(4);
    wait_end("basic");
    collect(start_cyc + 1);
    k = last_hs();
    checks++;
    if (ob_wa.size() != 4 || ob_hs.size() != 4) begin errors++; $display("FAIL basic_nwr: writes=%0d handshakes=%0d required 4 and 4", ob_wa.size(), ob_hs.size()); end
    for (int i = 0; i < ob_wa.size() && i < 4; i++) begin
      checks++;
      if (ob_wa[i] !== AW'(int'(b) + i) || ob_wd[i] !== tx_q[i] || ob_wc[i] != ob_hs[i] + 1) begin
        errors++; $display("FAIL basic_wr[%0d]: got addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d", i, ob_wa[i], ob_wd[i], ob_wc[i], AW'(int'(b) + i), tx_q[i], ob_hs[i] + 1);
      end
    end
    checks++;
    if (k - ob_hs[0] != 3) begin errors++; $display("FAIL basic_b2b: handshake span=%0d required 3", k - ob_hs[0]); end
    checks++;
    if (count !== 16'd4) begin errors++; $display("FAIL basic_count: got %0d required 4", count); end
    checks++;
    if (ob_done != k + 2) begin errors++; $display("FAIL basic_latency: done at %0d required %0d", ob_done, k + 2); end
    checks++;
    if (ob_trig != 1 || ob_trig_cyc != ob_done) begin errors++; $display("FAIL basic_trigger: pulses=%0d at %0d required 1 at %0d", ob_trig, ob_trig_cyc, ob_done); end
    checks++;
    if ({mem_own, cpu_hold, done, error} !== 4'b0010) begin errors++; $display("FAIL basic_release: mem_own,cpu_hold,done,error=%b required 0010", {mem_own, cpu_hold, done, error}); end
  endtask

  task automatic test_verify_pass();
    logic [AW-1:0] b;
    int k;
    b = INSTRUCTION_BASE;
    tx_q = '{8'hA9, 8'h05, 8'h69, 8'h03};
    gap_q = '{0, 0, 0, 0};
    do_start(b, 16'd4, 1'b1);
    send_bytes(4);
    wait_end("vpass");
    collect(start_cyc + 1);
    k = last_hs();
    checks++;
    if (ob_wa.size() != 4) begin errors++; $display("FAIL vpass_nwr: writes=%0d required 4", ob_wa.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (addr_h[hidx(k + 2 + i)] !== AW'(int'(b) + i)) begin
        errors++; $display("FAIL vpass_rdaddr[%0d]: got %h required %h", i, addr_h[hidx(k + 2 + i)], AW'(int'(b) + i));
      end
    end
    checks++;
    if (ob_done != k + 7 || ob_err != -1) begin errors++; $display("FAIL vpass_latency: done at %0d err at %0d required done at %0d no err", ob_done, ob_err, k + 7); end
    checks++;
    if (ob_trig != 1 || ob_trig_cyc != ob_done) begin errors++; $display("FAIL vpass_trigger: pulses=%0d at %0d required 1 at %0d", ob_trig, ob_trig_cyc, ob_done); end
  endtask

  task automatic test_verify_fail();
    int k;
    tx_q = '{8'hA9, 8'h05, 8'h69, 8'h03};
    gap_q = '{0, 0, 0, 0};
    do_start(INSTRUCTION_BASE, 16'd4, 1'b1);
    send_bytes(4);
    corrupt_addr = 16'h0202;
    corrupt_val = 8'h68;
    corrupt_en = 1'b1;
    wait_end("vfail");
    corrupt_en = 1'b0;
    collect(start_cyc + 1);
    k = last_hs();
    checks++;
    if (ob_err != k + 7 || ob_done != -1) begin errors++; $display("FAIL vfail_err: err at %0d done at %0d required err at %0d no done", ob_err, ob_done, k + 7); end
    checks++;
    if (ob_trig != 0) begin errors++; $display("FAIL vfail_trigger: pulses=%0d required 0", ob_trig); end
    checks++;
    if ({error, cpu_hold, mem_own, done} !== 4'b1110) begin errors++; $display("FAIL vfail_outs: error,cpu_hold,mem_own,done=%b required 1110", {error, cpu_hold, mem_own, done}); end
  endtask

  task automatic test_zero_len();
    din_valid = 1'b1;
    din = DW'($urandom);
    do_start(16'h1234, 16'd0, 1'b0);
    wait_end("zero");
    din_valid = 1'b0;
    collect(start_cyc + 1);
    checks++;
    if (ob_done != start_cyc + 1) begin errors++; $display("FAIL zero_latency: done at %0d required %0d", ob_done, start_cyc + 1); end
    checks++;
    if (ob_wa.size() != 0 || ob_rdy != 0) begin errors++; $display("FAIL zero_quiet: writes=%0d ready_seen=%0d required 0 and 0", ob_wa.size(), ob_rdy); end
    checks++;
    if (ob_trig != 1 || ob_trig_cyc != ob_done) begin errors++; $display("FAIL zero_trigger: pulses=%0d at %0d required 1 at %0d", ob_trig, ob_trig_cyc, ob_done); end
    checks++;
    if (count !== 16'd0 || cpu_hold !== 1'b0) begin errors++; $display("FAIL zero_state: count=%0d cpu_hold=%0b required 0 and 0", count, cpu_hold); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] b;
    int k;
    b = 16'hFFFE;
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    gap_q = '{0, 0, 2, 1};
    do_start(b, 16'd4, 1'b0);
    send_bytes(4);
    wait_end("wrap");
    collect(start_cyc + 1);
    k = last_hs();
    checks++;
    if (ob_wa.size() != 4 || ob_hs.size() != 4) begin errors++; $display("FAIL wrap_nwr: writes=%0d handshakes=%0d required 4 and 4", ob_wa.size(), ob_hs.size()); end
    for (int i = 0; i < ob_wa.size() && i < 4; i++) begin
      checks++;
      if (ob_wa[i] !== AW'(int'(b) + i) || ob_wd[i] !== tx_q[i] || ob_wc[i] != ob_hs[i] + 1) begin
        errors++; $display("FAIL wrap_wr[%0d]: got addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d", i, ob_wa[i], ob_wd[i], ob_wc[i], AW'(int'(b) + i), tx_q[i], ob_hs[i] + 1);
      end
    end
    checks++;
    if (ob_done != k + 2 || count !== 16'd4) begin errors++; $display("FAIL wrap_end: done at %0d count=%0d required %0d and 4", ob_done, count, k + 2); end
  endtask

  task automatic test_reset_mid();
    int r, k;
    tx_q = '{8'h5A, 8'hC3, 8'h7E, 8'h81};
    gap_q = '{0, 0, 0, 0};
    do_start(16'h0300, 16'd4, 1'b0);
    send_bytes(2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    r = cyc;
    checks++;
    if ({mem_we, busy, done, error} !== 4'b0000) begin errors++; $display("FAIL rmid_ctrl: mem_we,busy,done,error=%b required 0000", {mem_we, busy, done, error}); end
    checks++;
    if ({cpu_hold, mem_own} !== 2'b11 || count !== 16'd0) begin errors++; $display("FAIL rmid_hold: cpu_hold,mem_own=%b count=%0d required 11 and 0", {cpu_hold, mem_own}, count); end
    repeat (3) @(negedge clk);
    #1;
    collect(r);
    checks++;
    if (ob_wa.size() != 0) begin errors++; $display("FAIL rmid_nowrite: writes=%0d required 0", ob_wa.size()); end
    for (int i = 0; i < 4; i++) tx_q[i] = DW'($urandom);
    do_start(16'h0400, 16'd4, 1'b1);
    send_bytes(4);
    wait_end("rmid");
    collect(start_cyc + 1);
    k = last_hs();
    checks++;
    if (ob_wa.size() != 4 || count !== 16'd4) begin errors++; $display("FAIL rmid_reload: writes=%0d count=%0d required 4 and 4", ob_wa.size(), count); end
    checks++;
    if (ob_done != k + 7 || ob_err != -1 || ob_trig != 1) begin errors++; $display("FAIL rmid_finish: done at %0d err at %0d pulses=%0d required %0d, none, 1", ob_done, ob_err, ob_trig, k + 7); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [AW-1:0] b;
      int len, k, lat;
      logic v;
      b = AW'($urandom);
      len = $urandom_range(1, 8);
      v = 1'($urandom_range(0, 1));
      tx_q.delete();
      gap_q.delete();
      for (int i = 0; i < len; i++) begin
        tx_q.push_back(DW'($urandom));
        gap_q.push_back($urandom_range(0, 2));
      end
      do_start(b, AW'(len), v);
      send_bytes(len);
      wait_end("rand");
      collect(start_cyc + 1);
      k = last_hs();
      lat = v ? len + 3 : 2;
      checks++;
      if (ob_wa.size() != len || ob_hs.size() != len) begin errors++; $display("FAIL rand%0d_nwr: writes=%0d handshakes=%0d required %0d", it, ob_wa.size(), ob_hs.size(), len); end
      for (int i = 0; i < ob_wa.size() && i < len; i++) begin
        checks++;
        if (ob_wa[i] !== AW'(int'(b) + i) || ob_wd[i] !== tx_q[i] || ob_wc[i] != ob_hs[i] + 1) begin
          errors++; $display("FAIL rand%0d_wr[%0d]: got addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d", it, i, ob_wa[i], ob_wd[i], ob_wc[i], AW'(int'(b) + i), tx_q[i], ob_hs[i] + 1);
        end
      end
      checks++;
      if (ob_done != k + lat || ob_err != -1 || count !== AW'(len)) begin
        errors++; $display("FAIL rand%0d_end: done at %0d err at %0d count=%0d required done at %0d no err count=%0d", it, ob_done, ob_err, count, k + lat, len);
      end
      checks++;
      if (ob_trig != 1 || ob_trig_cyc != ob_done) begin errors++; $display("FAIL rand%0d_trigger: pulses=%0d at %0d required 1 at %0d", it, ob_trig, ob_trig_cyc, ob_done); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    verify_en = 1'b0;
    din = '0;
    din_valid = 1'b0;
    corrupt_en = 1'b0;
    corrupt_addr = '0;
    corrupt_val = '0;
    test_reset();
    test_basic();
    test_verify_pass();
    test_verify_fail();
    test_zero_len();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
